// File: rtl/reg_hex_display.sv
// Four-digit hex display of one halfword of a 32-bit register value.
// The scan snapshots number and the halfword select once per frame so a
// digit never shows a mix of old and new data. A debounced pushbutton
// toggles which halfword is shown; the change takes effect at a frame
// boundary.
//
// Ports:
//   clock     board clock, rising edge
//   reset_n   asynchronous active-low reset
//   number    32-bit value to display (asynchronous to the scan)
//   half_btn  raw bouncing pushbutton; each press toggles the halfword
//   Anodes    digit enables, active-low, bit 0 = rightmost digit
//   Cathodes  segments {g,f,e,d,c,b,a}, active-low
//   half_led  1 = number[31:16] shown, 0 = number[15:0] shown
module reg_hex_display #(
    parameter int unsigned REFRESH_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] number,
    input  logic        half_btn,
    output logic [3:0]  Anodes,
    output logic [6:0]  Cathodes,
    output logic        half_led
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [REF_W-1:0] ref_cnt;
    logic [1:0]       digit_idx;
    logic [31:0]      snapshot;
    logic             sync1;
    logic             sync2;
    logic [DB_W-1:0]  db_cnt;
    logic             db_level;
    logic             half_tog;

    logic             tick;
    logic             frame_end;
    logic             db_differ;
    logic             db_fire;
    logic             db_rise;
    logic [15:0]      half_word;
    logic [3:0]       nibble;
    logic [3:0]       anodes_nxt;
    logic [6:0]       seg_nxt;

    // Scan timing and debounce decisions
    always_comb begin
        tick      = (ref_cnt == REF_W'(REFRESH_DIV - 1));
        frame_end = tick && (digit_idx == 2'd3);
        db_differ = (sync2 != db_level);
        db_fire   = db_differ && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
        db_rise   = db_fire && sync2;
    end

    // Digit data path: select halfword, nibble, anode and glyph
    always_comb begin
        half_word  = half_led ? snapshot[31:16] : snapshot[15:0];
        nibble     = half_word[3:0];
        anodes_nxt = 4'b1110;
        case (digit_idx)
            2'd0: begin nibble = half_word[3:0];   anodes_nxt = 4'b1110; end
            2'd1: begin nibble = half_word[7:4];   anodes_nxt = 4'b1101; end
            2'd2: begin nibble = half_word[11:8];  anodes_nxt = 4'b1011; end
            default: begin nibble = half_word[15:12]; anodes_nxt = 4'b0111; end
        endcase
        seg_nxt = 7'h7F;
        case (nibble)
            4'h0: seg_nxt = 7'h40;
            4'h1: seg_nxt = 7'h79;
            4'h2: seg_nxt = 7'h24;
            4'h3: seg_nxt = 7'h30;
            4'h4: seg_nxt = 7'h19;
            4'h5: seg_nxt = 7'h12;
            4'h6: seg_nxt = 7'h02;
            4'h7: seg_nxt = 7'h78;
            4'h8: seg_nxt = 7'h00;
            4'h9: seg_nxt = 7'h10;
            4'hA: seg_nxt = 7'h08;
            4'hB: seg_nxt = 7'h03;
            4'hC: seg_nxt = 7'h46;
            4'hD: seg_nxt = 7'h21;
            4'hE: seg_nxt = 7'h06;
            default: seg_nxt = 7'h0E;
        endcase
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt   <= '0;
            digit_idx <= '0;
            snapshot  <= '0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            db_cnt    <= '0;
            db_level  <= 1'b0;
            half_tog  <= 1'b0;
            half_led  <= 1'b0;
            Anodes    <= 4'hF;
            Cathodes  <= 7'h7F;
        end else begin
            sync1 <= half_btn;
            sync2 <= sync1;

            if (!db_differ) begin
                db_cnt <= '0;
            end else if (db_fire) begin
                db_cnt   <= '0;
                db_level <= sync2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            if (db_rise) begin
                half_tog <= ~half_tog;
            end

            ref_cnt <= tick ? '0 : ref_cnt + REF_W'(1);
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
            end

            // Pre-edge half_tog is captured, so a same-edge toggle waits a frame
            if (frame_end) begin
                snapshot <= number;
                half_led <= half_tog;
            end

            Anodes   <= anodes_nxt;
            Cathodes <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_reg_hex_display.sv
module tb_reg_hex_display;

    localparam int unsigned DIV = 4;
    localparam int unsigned DEB = 8;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cat;
        logic       led;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] number;
    logic        half_btn;
    logic [3:0]  Anodes;
    logic [6:0]  Cathodes;
    logic        half_led;

    int tests  = 0;
    int errors = 0;

    exp_t exp_q[$];

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    reg_hex_display #(.REFRESH_DIV(DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .number   (number),
        .half_btn (half_btn),
        .Anodes   (Anodes),
        .Cathodes (Cathodes),
        .half_led (half_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since reset, frame snapshots, run-length debounce
    int unsigned m_k;
    logic [31:0] m_snap;
    bit          m_disp, m_tog, m_deb, m_h1, m_h2;
    int          m_run;

    task automatic model_reset();
        m_k = 0; m_snap = '0; m_disp = 0; m_tog = 0; m_deb = 0;
        m_h1 = 0; m_h2 = 0; m_run = 0;
    endtask

    task automatic model_step();
        exp_t        e;
        int unsigned digit;
        logic [15:0] hw;
        logic [3:0]  nib;
        bit          synced;
        digit = (m_k / DIV) % 4;
        hw    = m_disp ? m_snap[31:16] : m_snap[15:0];
        nib   = 4'(hw >> (4 * digit));
        e.an  = 4'hF ^ 4'(1 << digit);
        e.cat = font[nib];
        if ((m_k % (4 * DIV)) == (4 * DIV - 1)) begin
            m_snap = number;
            m_disp = m_tog;
        end
        synced = m_h2;
        if (synced == m_deb) m_run = 0;
        else begin
            m_run++;
            if (m_run == DEB) begin
                m_deb = synced;
                m_run = 0;
                if (synced) m_tog = ~m_tog;
            end
        end
        m_h2 = m_h1;
        m_h1 = half_btn;
        e.led = m_disp;
        exp_q.push_back(e);
        m_k++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step();
            end
        end
    end

    // Monitor: compare every presented output against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("reset_outputs", {Anodes, Cathodes, half_led}, {4'hF, 7'h7F, 1'b0});
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scan_outputs", {Anodes, Cathodes, half_led}, {e.an, e.cat, e.led});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic hold_btn(input logic v, input int n);
        half_btn = v;
        cycles(n);
    endtask

    bit exp_led;

    initial begin
        reset_n  = 1'b0;
        number   = 32'h1234ABCD;
        half_btn = 1'b0;
        exp_led  = 0;
        cycles(3);
        check("reset_anodes", 32'(Anodes), 32'hF);
        check("reset_cathodes", 32'(Cathodes), 32'h7F);
        reset_n = 1'b1;

        // First frame shows 0, second frame shows the low halfword
        repeat (17) @(posedge clock);
        @(negedge clock);
        check("first_digit_cat", 32'(Cathodes), 32'h21);
        check("first_digit_an", 32'(Anodes), 32'hE);
        check("first_led", 32'(half_led), 32'h0);
        cycles(50);

        // Clean press
        hold_btn(1'b1, 20);
        hold_btn(1'b0, 40);
        exp_led = 1;
        check("clean_press_led", 32'(half_led), 32'(exp_led));

        // Short pulse: no toggle
        hold_btn(1'b1, 5);
        hold_btn(1'b0, 40);
        check("short_pulse_led", 32'(half_led), 32'(exp_led));

        // Bouncing then held
        for (int i = 0; i < 5; i++) begin
            hold_btn(1'b1, 3);
            hold_btn(1'b0, 3);
        end
        hold_btn(1'b1, 20);
        hold_btn(1'b0, 40);
        exp_led = 0;
        check("bounce_press_led", 32'(half_led), 32'(exp_led));

        // Number change mid-frame: no tearing
        number = 32'h0;
        cycles(40);
        cycles($urandom_range(0, 15));
        number = 32'hFFFFFFFF;
        cycles(40);

        // Reset mid-frame with half_led = 1
        hold_btn(1'b1, 12);
        hold_btn(1'b0, 40);
        check("pre_reset_led", 32'(half_led), 32'h1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_an", 32'(Anodes), 32'hF);
        check("async_reset_cat", 32'(Cathodes), 32'h7F);
        check("async_reset_led", 32'(half_led), 32'h0);
        cycles(2);
        reset_n = 1'b1;
        exp_led = 0;
        cycles(40);
        check("post_reset_led", 32'(half_led), 32'(exp_led));

        // Press at every phase of the frame, including the boundary edge
        for (int off = 0; off < 16; off++) begin
            cycles(off);
            number = $urandom;
            hold_btn(1'b1, 12);
            hold_btn(1'b0, 12);
            cycles(40);
            exp_led = ~exp_led;
            check("sweep_led", 32'(half_led), 32'(exp_led));
        end

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) number = $urandom;
            half_btn = 1'($urandom_range(0, 1));
            cycles($urandom_range(1, 20));
        end
        half_btn = 1'b0;
        cycles(40);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/reg_hex_display.md
REG_HEX_DISPLAY -- requirements
Module: reg_hex_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clocks each digit is lit (1 kHz digit rate at 100 MHz).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, clocks the synchronized button must stay stable before its debounced level updates.
REQ-003 clock  input  1  board clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 number  input  32  register-file value selected by RegisterIndex; asynchronous to the display scan.
REQ-006 half_btn  input  1  raw, bouncing pushbutton; each debounced press toggles the displayed halfword.
REQ-007 Anodes  output  4  digit enables, active-low; bit 0 is the rightmost digit.
REQ-008 Cathodes  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 half_led  output  1  1 = upper halfword number[31:16] displayed; 0 = lower halfword number[15:0].

Function
REQ-010 Refresh counter shall count 0..REFRESH_DIV-1 and wrap to 0; the edge where it equals REFRESH_DIV-1 is a "tick".
REQ-011 Digit index shall be 2 bits, increment on each tick, and wrap 3->0.
REQ-012 On a tick with digit index 3 (frame boundary), the snapshot register shall load number and the displayed-half register shall load the current half toggle state, in the same edge.
REQ-013 Between frame boundaries, changes on number or half toggle shall not alter the displayed digits (no tearing).
REQ-014 Displayed halfword = snapshot[31:16] if displayed-half = 1, else snapshot[15:0].
REQ-015 Digit index k shall drive Anodes low on bit k only (0:1110, 1:1101, 2:1011, 3:0111) and show nibble [4k+3:4k] of the displayed halfword.
REQ-016 Anodes and Cathodes shall be registered: each reflects the digit index and displayed halfword present before the same clock edge (one-cycle latency).
REQ-017 Hex font (Cathodes, hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-018 half_btn shall pass through a 2-flop synchronizer before any other use.
REQ-019 Debounce counter shall clear whenever the synchronized level equals the debounced level, otherwise increment; when it reaches DEBOUNCE_CYCLES-1 the debounced level shall take the synchronized level and the counter shall clear.
REQ-020 A debounced 0->1 transition shall toggle the half toggle state exactly once; a debounced 1->0 transition shall have no effect.
REQ-021 A button pulse shorter than DEBOUNCE_CYCLES clocks after synchronization shall cause no toggle.
REQ-022 half_led shall equal the displayed-half register (not the pending toggle state).
REQ-023 Toggle and frame boundary on the same edge: the snapshot shall capture the toggle state from before that edge; the new toggle state is displayed at the next frame boundary.

Reset
REQ-024 While reset_n = 0: Anodes = 1111, Cathodes = 1111111, half_led = 0, digit index = 0, refresh and debounce counters = 0, snapshot = 0, half toggle and debounced level = 0, synchronizer flops = 0.
REQ-025 Reset assertion mid-frame or mid-debounce shall abandon the operation immediately with no pending toggle retained.
REQ-026 From the first rising edge after reset_n release, the scan shall start at digit 0 displaying 0000 until the first frame boundary.

Verification (REFRESH_DIV=4, DEBOUNCE_CYCLES=8)
REQ-027 Reset, number=32'h1234ABCD held -> after first frame boundary, digits 0..3 show D,C,B,A (Cathodes 21,46,03,08) with Anodes 1110,1101,1011,0111, 4 clocks each; half_led=0.
REQ-028 Press half_btn clean for 20 clocks -> exactly one toggle; at the next frame boundary half_led=1 and digits show 4,3,2,1 (19,30,24,79).
REQ-029 half_btn bounces 3-clock pulses for 30 clocks, then held high -> exactly one toggle; a 5-clock pulse alone -> no toggle.
REQ-030 number changes 32'h0->32'hFFFFFFFF while digit index = 1 -> digits 1..3 of that frame still show 0 (40); next frame shows F (0E).
REQ-031 Assert reset_n low mid-frame with half_led=1 -> same cycle Anodes=1111, Cathodes=1111111, half_led=0; after release scan restarts at digit 0 showing 0.
REQ-032 Toggle landing on the frame-boundary edge -> half_led unchanged that frame, changes at the following boundary (16 clocks later).
